// File: rtl/bounded_updown_counter_pkg.sv
// Shared types and constants for the bounded up/down counter slice.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STEP_UP,
        STEP_DN,
        HOLD
    } state_t;

    localparam int unsigned MODE_SAT  = 0;
    localparam int unsigned MODE_WRAP = 1;

endpackage

// File: rtl/bounded_updown_counter_if.sv
// Button/control inputs and count/status outputs of the bounded up/down counter.
interface bounded_updown_counter_if #(
    parameter int unsigned WIDTH = 16
);

    logic             U;
    logic             D;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             changed;

    modport master (
        output U, D, clr,
        input  count, at_max, at_min, changed
    );

    modport slave (
        input  U, D, clr,
        output count, at_max, at_min, changed
    );

endinterface

// File: rtl/bounded_updown_counter_button_conditioner.sv
// Raw push-button conditioning: 2-FF synchroniser, debounce counter, rising-edge pulse.
module button_conditioner #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic quiet
);

    localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            level_d <= level;
            press   <= level & ~level_d;
            // Level flips on the DEB_CYCLES-th consecutive differing sample.
            if (sync_p1 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                level   <= sync_p1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Nothing in flight anywhere in the chain: button is genuinely released.
    assign quiet = ~(sync_p0 | sync_p1 | level) & (deb_cnt == '0);

endmodule

// File: rtl/bounded_updown_counter.sv
// Button-driven up/down counter stepping by STEP between MIN_VAL and MAX_VAL,
// saturating or wrapping at the bounds, with synchronous clear and status flags.
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 2**WIDTH - 1,
    parameter int unsigned STEP       = 1,
    parameter int unsigned WRAP       = MODE_SAT,
    parameter int unsigned DEB_CYCLES = 4
) (
    input logic                     clk,
    input logic                     rst,
    bounded_updown_counter_if.slave bus
);

    localparam logic [WIDTH:0] MIN_X  = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

    if (!(MIN_VAL < MAX_VAL && MAX_VAL <= 2**WIDTH - 1 &&
          STEP >= 1 && STEP <= MAX_VAL - MIN_VAL && DEB_CYCLES >= 2)) begin : g_param_check
        $error("bounded_updown_counter: illegal parameter combination");
    end

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur} + STEP_X;
        if (sum > MAX_X)
            return (WRAP == MODE_WRAP) ? MIN_X[WIDTH-1:0] : MAX_X[WIDTH-1:0];
        return sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] diff;
        diff = {1'b0, cur} - STEP_X;
        if ({1'b0, cur} < MIN_X + STEP_X)
            return (WRAP == MODE_WRAP) ? MAX_X[WIDTH-1:0] : MIN_X[WIDTH-1:0];
        return diff[WIDTH-1:0];
    endfunction

    logic             up_press;
    logic             up_quiet;
    logic             dn_press;
    logic             dn_quiet;
    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] step_val;
    logic             changed_q;
    logic             armed;

    button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.U),
        .press (up_press),
        .quiet (up_quiet)
    );

    button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.D),
        .press (dn_press),
        .quiet (dn_quiet)
    );

    always_comb begin
        step_val = (state_q == STEP_DN) ? step_dn(count_q) : step_up(count_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HOLD;
            count_q   <= MIN_X[WIDTH-1:0];
            changed_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed     <= 1'b1;
            changed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (up_press && dn_press)  state_q <= HOLD;
                    else if (up_press)         state_q <= STEP_UP;
                    else if (dn_press)         state_q <= STEP_DN;
                end
                STEP_UP, STEP_DN: state_q <= HOLD;
                // armed keeps the first post-reset cycle in HOLD, before the
                // synchroniser has seen a button held through reset.
                HOLD: if (armed && up_quiet && dn_quiet) state_q <= IDLE;
                default: state_q <= HOLD;
            endcase
            if (bus.clr) begin
                count_q   <= MIN_X[WIDTH-1:0];
                changed_q <= (count_q != MIN_X[WIDTH-1:0]);
            end else if (state_q == STEP_UP || state_q == STEP_DN) begin
                count_q   <= step_val;
                changed_q <= (step_val != count_q);
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.changed = changed_q;
    assign bus.at_max  = (count_q == MAX_X[WIDTH-1:0]);
    assign bus.at_min  = (count_q == MIN_X[WIDTH-1:0]);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench for bounded_updown_counter: three parameter sets share one clock.
module tb_bounded_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   chg_a  = 0;
    int   chg_b  = 0;
    int   base;

    always #5 clk = ~clk;

    bounded_updown_counter_if #(.WIDTH(16)) a_if ();
    bounded_updown_counter_if #(.WIDTH(4))  b_if ();
    bounded_updown_counter_if #(.WIDTH(4))  c_if ();

    bounded_updown_counter #(.WIDTH(16)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if)
    );

    bounded_updown_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(10), .STEP(3), .WRAP(0)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if)
    );

    bounded_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .STEP(1), .WRAP(1)) dut_c (
        .clk (clk), .rst (rst), .bus (c_if)
    );

    // Tally of cycles each DUT held changed high, sampled before the edge updates it.
    always @(posedge clk) begin
        if (a_if.changed === 1'b1) chg_a <= chg_a + 1;
        if (b_if.changed === 1'b1) chg_b <= chg_b + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input int dut, input bit up, input logic v);
        case (dut)
            0: if (up) a_if.U = v; else a_if.D = v;
            1: if (up) b_if.U = v; else b_if.D = v;
            default: if (up) c_if.U = v; else c_if.D = v;
        endcase
    endtask

    task automatic press(input int dut, input bit up);
        drive(dut, up, 1'b1);
        cyc(12);
        drive(dut, up, 1'b0);
        cyc(12);
    endtask

    initial begin
        a_if.U = 1'b1; a_if.D = 1'b0; a_if.clr = 1'b0;
        b_if.U = 1'b0; b_if.D = 1'b0; b_if.clr = 1'b0;
        c_if.U = 1'b0; c_if.D = 1'b0; c_if.clr = 1'b0;
        cyc(3);

        // Reset values, with U already held on A
        chk("rst_count_a",   a_if.count,   0);
        chk("rst_at_min_a",  a_if.at_min,  1);
        chk("rst_at_max_a",  a_if.at_max,  0);
        chk("rst_changed_a", a_if.changed, 0);
        chk("rst_count_c",   c_if.count,   2);
        chk("rst_at_min_c",  c_if.at_min,  1);

        rst = 1'b1;
        cyc(20);
        chk("held_through_reset", a_if.count, 0);
        a_if.U = 1'b0;
        cyc(12);
        press(0, 1'b1);
        chk("repress_after_reset", a_if.count, 1);

        // Latency: U sampled high at edge k, count moves at edge k+8
        base = chg_a;
        a_if.U = 1'b1;
        cyc(8);
        chk("latency_before",     a_if.count,   1);
        chk("latency_before_chg", a_if.changed, 0);
        cyc(1);
        chk("latency_update",     a_if.count,   2);
        chk("latency_changed",    a_if.changed, 1);
        cyc(1);
        chk("latency_changed_end", a_if.changed, 0);
        cyc(4);
        a_if.U = 1'b0;
        cyc(12);
        chk("latency_single_pulse", chg_a - base, 1);

        // Bounce: toggling every cycle never settles
        base = chg_a;
        repeat (20) begin
            a_if.U = ~a_if.U;
            cyc(1);
        end
        cyc(12);
        chk("bounce_count",   a_if.count,   2);
        chk("bounce_changed", chg_a - base, 0);

        // Simultaneous U and D presses
        base = chg_a;
        a_if.U = 1'b1; a_if.D = 1'b1;
        cyc(14);
        chk("both_count", a_if.count, 2);
        a_if.U = 1'b0; a_if.D = 1'b0;
        cyc(12);
        chk("both_changed", chg_a - base, 0);
        press(0, 1'b1);
        chk("after_both_up", a_if.count, 3);

        // clr during the STEP_UP cycle drops the step
        a_if.U = 1'b1;
        cyc(8);
        a_if.clr = 1'b1;
        cyc(1);
        chk("clr_count",   a_if.count,   0);
        chk("clr_changed", a_if.changed, 1);
        a_if.clr = 1'b0;
        cyc(1);
        chk("clr_step_dropped", a_if.count,   0);
        chk("clr_changed_end",  a_if.changed, 0);
        cyc(3);
        a_if.U = 1'b0;
        cyc(12);
        chk("clr_no_late_step", a_if.count, 0);

        // clr at MIN_VAL and saturated down step leave changed low
        base = chg_a;
        a_if.clr = 1'b1;
        cyc(1);
        a_if.clr = 1'b0;
        press(0, 1'b0);
        chk("sat_min_count",   a_if.count,   0);
        chk("sat_min_at_min",  a_if.at_min,  1);
        chk("sat_min_changed", chg_a - base, 0);

        // Saturate: STEP=3, MAX_VAL=10
        press(1, 1'b1);
        press(1, 1'b1);
        press(1, 1'b1);
        chk("sat_count_9",  b_if.count,  9);
        chk("sat_at_max_9", b_if.at_max, 0);
        press(1, 1'b1);
        chk("sat_count_10", b_if.count,  10);
        chk("sat_at_max",   b_if.at_max, 1);
        base = chg_b;
        press(1, 1'b1);
        chk("sat_hold_count",   b_if.count,   10);
        chk("sat_hold_changed", chg_b - base, 0);

        // Wrap: MIN_VAL=2, MAX_VAL=10
        press(2, 1'b0);
        chk("wrap_dn_count",  c_if.count,  10);
        chk("wrap_dn_at_max", c_if.at_max, 1);
        chk("wrap_dn_at_min", c_if.at_min, 0);
        press(2, 1'b1);
        chk("wrap_up_count",  c_if.count,  2);
        chk("wrap_up_at_min", c_if.at_min, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
